spi_master_ctrl: RTL and testbench

Transaction sequencer for the SPI master datapath. Latches a transaction descriptor and runs its phases in a fixed order: CMD, ADDR, DUMMY, DATA_WR, DATA_RD. It drives the enable, counter-load, quad-mode and TX-source controls of the TX and RX shifters, counts dummy cycles itself, and owns chip-select. It sits between the register/AXI front-end and the TX/RX shifters plus the SPI clock generator.

---
 rtl/spi_ctrl_pkg.sv | 41 ++++
 rtl/spi_master_ctrl_if.sv | 62 ++++++
 rtl/spi_dummy_counter.sv | 35 +++
 rtl/spi_master_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_ctrl_pkg: shared types, constants and phase-skip helper for the  |
// | SPI master transaction sequencer.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_ctrl_pkg;

  localparam int unsigned c_CS_SEL_W  = 2;
  localparam int unsigned c_CMD_LEN_W = 6;
  localparam int unsigned c_CNT_W     = 16;

  localparam logic [1:0] TXSRC_FIFO = 2'd0;
  localparam logic [1:0] TXSRC_CMD  = 2'd1;
  localparam logic [1:0] TXSRC_ADDR = 2'd2;

  // Encoding order matches phase order; next_phase relies on it.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_DATA_RD = 3'd5,
    ST_EOT     = 3'd6
  } state_t;

  // nz = {rd, wr, dummy, addr, cmd} nonzero-length flags
  function automatic state_t next_phase(input state_t cur, input logic [4:0] nz);
    state_t nxt;
    nxt = ST_EOT;
    if (nz[4] && (cur < ST_DATA_RD)) nxt = ST_DATA_RD;
    if (nz[3] && (cur < ST_DATA_WR)) nxt = ST_DATA_WR;
    if (nz[2] && (cur < ST_DUMMY))   nxt = ST_DUMMY;
    if (nz[1] && (cur < ST_ADDR))    nxt = ST_ADDR;
    if (nz[0] && (cur < ST_CMD))     nxt = ST_CMD;
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_ctrl_if: descriptor, shifter and chip-select signals of   |
// | the SPI master sequencer.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface spi_master_ctrl_if #(
  parameter int NUM_CS = 4,
  parameter int LEN_W  = 16
);
  import spi_ctrl_pkg::*;

  logic                   start;
  logic                   abort;
  logic [c_CS_SEL_W-1:0]  cs_sel;
  logic                   en_quad;
  logic [31:0]            cmd;
  logic [c_CMD_LEN_W-1:0] cmd_len;
  logic [31:0]            addr;
  logic [c_CMD_LEN_W-1:0] addr_len;
  logic [LEN_W-1:0]       dummy_len;
  logic [LEN_W-1:0]       wr_len;
  logic [LEN_W-1:0]       rd_len;
  logic                   spi_rise;
  logic                   tx_done;
  logic                   rx_done;
  logic                   tx_clk_en;
  logic                   rx_clk_en;
  logic                   tx_en;
  logic                   rx_en;
  logic [c_CNT_W-1:0]     tx_counter;
  logic                   tx_counter_upd;
  logic [c_CNT_W-1:0]     rx_counter;
  logic                   rx_counter_upd;
  logic [1:0]             tx_src;
  logic [31:0]            tx_data;
  logic                   en_quad_o;
  logic                   clk_en_o;
  logic [NUM_CS-1:0]      csn;
  logic                   busy;
  logic                   eot;

  modport master (
    input  start, abort, cs_sel, en_quad, cmd, cmd_len, addr, addr_len,
           dummy_len, wr_len, rd_len, spi_rise, tx_done, rx_done,
           tx_clk_en, rx_clk_en,
    output tx_en, rx_en, tx_counter, tx_counter_upd, rx_counter,
           rx_counter_upd, tx_src, tx_data, en_quad_o, clk_en_o, csn,
           busy, eot
  );

  modport slave (
    output start, abort, cs_sel, en_quad, cmd, cmd_len, addr, addr_len,
           dummy_len, wr_len, rd_len, spi_rise, tx_done, rx_done,
           tx_clk_en, rx_clk_en,
    input  tx_en, rx_en, tx_counter, tx_counter_upd, rx_counter,
           rx_counter_upd, tx_src, tx_data, en_quad_o, clk_en_o, csn,
           busy, eot
  );

endinterface
`default_nettype wire

// File: rtl/spi_dummy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_dummy_counter: counts SPI rising edges during the dummy phase    |
// | and flags the edge that completes the programmed count.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_dummy_counter #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             spi_rise,
  input  logic [LEN_W-1:0] target,
  output logic             done
);

  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_last;

  assign w_last = target - LEN_W'(1);
  assign done   = !clear && spi_rise && (r_count == w_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (spi_rise) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_ctrl: sequences CMD/ADDR/DUMMY/DATA_WR/DATA_RD phases of  |
// | one SPI transaction and owns chip-select.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_CS = 4,
  parameter int LEN_W  = 16
) (
  input logic              clk,
  input logic              rstn,
  spi_master_ctrl_if.master bus
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_entry;
  logic                   w_entry_next;
  logic                   w_accept;
  logic [4:0]             w_nz_in;
  logic [4:0]             w_nz;
  logic                   w_dummy_done;
  logic                   w_cs_low;

  logic [c_CS_SEL_W-1:0]  r_cs_sel;
  logic                   r_en_quad;
  logic [31:0]            r_cmd;
  logic [c_CMD_LEN_W-1:0] r_cmd_len;
  logic [31:0]            r_addr;
  logic [c_CMD_LEN_W-1:0] r_addr_len;
  logic [LEN_W-1:0]       r_dummy_len;
  logic [LEN_W-1:0]       r_wr_len;
  logic [LEN_W-1:0]       r_rd_len;
  logic                   r_cs_hold_eot;

  assign w_accept = bus.start && !bus.abort && (r_state == ST_IDLE);
  assign w_nz_in  = {bus.rd_len != '0, bus.wr_len != '0, bus.dummy_len != '0,
                     bus.addr_len != '0, bus.cmd_len != '0};
  assign w_nz     = {r_rd_len != '0, r_wr_len != '0, r_dummy_len != '0,
                     r_addr_len != '0, r_cmd_len != '0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs_sel      <= '0;
      r_en_quad     <= 1'b0;
      r_cmd         <= '0;
      r_cmd_len     <= '0;
      r_addr        <= '0;
      r_addr_len    <= '0;
      r_dummy_len   <= '0;
      r_wr_len      <= '0;
      r_rd_len      <= '0;
      r_cs_hold_eot <= 1'b0;
    end else if (w_accept) begin
      r_cs_sel      <= bus.cs_sel;
      r_en_quad     <= bus.en_quad;
      r_cmd         <= bus.cmd;
      r_cmd_len     <= bus.cmd_len;
      r_addr        <= bus.addr;
      r_addr_len    <= bus.addr_len;
      r_dummy_len   <= bus.dummy_len;
      r_wr_len      <= bus.wr_len;
      r_rd_len      <= bus.rd_len;
      // An empty transaction keeps CS low through its single EOT cycle.
      r_cs_hold_eot <= (w_nz_in == 5'b0);
    end
  end

  spi_dummy_counter #(
    .LEN_W (LEN_W)
  ) u_dummy_counter (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (r_state != ST_DUMMY),
    .spi_rise (bus.spi_rise),
    .target   (r_dummy_len),
    .done     (w_dummy_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_entry <= w_entry_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    bus.tx_en          = 1'b0;
    bus.rx_en          = 1'b0;
    bus.tx_counter     = '0;
    bus.tx_counter_upd = 1'b0;
    bus.rx_counter     = '0;
    bus.rx_counter_upd = 1'b0;
    bus.tx_src         = TXSRC_FIFO;
    bus.tx_data        = '0;
    bus.en_quad_o      = 1'b0;
    bus.clk_en_o       = 1'b0;
    bus.eot            = 1'b0;
    w_cs_low           = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_cs_low = 1'b0;
        if (bus.start) w_state_next = next_phase(ST_IDLE, w_nz_in);
      end
      ST_CMD, ST_ADDR, ST_DATA_WR: begin
        bus.tx_en          = !r_entry;
        bus.tx_counter_upd = r_entry;
        bus.clk_en_o       = bus.tx_clk_en;
        if (r_entry) begin
          bus.tx_counter = (r_state == ST_CMD)  ? c_CNT_W'(r_cmd_len)  :
                           (r_state == ST_ADDR) ? c_CNT_W'(r_addr_len) :
                                                  c_CNT_W'(r_wr_len);
        end
        if (r_state == ST_CMD) begin
          bus.tx_src  = TXSRC_CMD;
          bus.tx_data = r_cmd;
        end else if (r_state == ST_ADDR) begin
          bus.tx_src    = TXSRC_ADDR;
          bus.tx_data   = r_addr;
          bus.en_quad_o = r_en_quad;
        end else begin
          bus.en_quad_o = r_en_quad;
        end
        if (!r_entry && bus.tx_done) w_state_next = next_phase(r_state, w_nz);
      end
      ST_DUMMY: begin
        bus.clk_en_o = 1'b1;
        if (w_dummy_done) w_state_next = next_phase(r_state, w_nz);
      end
      ST_DATA_RD: begin
        bus.rx_en          = !r_entry;
        bus.rx_counter_upd = r_entry;
        bus.en_quad_o      = r_en_quad;
        bus.clk_en_o       = bus.rx_clk_en;
        if (r_entry) bus.rx_counter = c_CNT_W'(r_rd_len);
        if (!r_entry && bus.rx_done) w_state_next = next_phase(r_state, w_nz);
      end
      ST_EOT: begin
        bus.eot      = 1'b1;
        w_cs_low     = r_cs_hold_eot;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_cs_low     = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase

    if (bus.abort) w_state_next = ST_IDLE;
    // Every state change lands in a fresh phase, so it opens an entry cycle.
    w_entry_next = (w_state_next != r_state);
  end

  assign bus.busy = (r_state != ST_IDLE);

  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_csn
    assign bus.csn[gi] = ~(w_cs_low && (r_cs_sel == c_CS_SEL_W'(gi)));
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_master_ctrl: randomized self-checking bench for the SPI       |
// | master sequencer against a phase-list reference model.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_master_ctrl;

  localparam int P_CMD = 1, P_ADDR = 2, P_DUMMY = 3, P_WR = 4, P_RD = 5;
  localparam int M_NORMAL = 0, M_DISTURB = 1, M_ABORT_WR = 2, M_RESET_DUMMY = 3;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.NUM_CS(4), .LEN_W(16)) bus ();

  spi_master_ctrl #(.NUM_CS(4), .LEN_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  // {busy, eot, csn[3:0], tx_en, rx_en, tx_upd, rx_upd, en_quad_o, clk_en_o}
  function automatic logic [11:0] pack(input logic b, input logic e, input logic [3:0] c,
                                       input logic te, input logic re, input logic tu,
                                       input logic ru, input logic q, input logic ce);
    return {b, e, c, te, re, tu, ru, q, ce};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.busy, bus.eot, bus.csn, bus.tx_en, bus.rx_en, bus.tx_counter_upd,
            bus.rx_counter_upd, bus.en_quad_o, bus.clk_en_o};
  endfunction

  task automatic drive_idle();
    bus.start = 0; bus.abort = 0; bus.spi_rise = 0; bus.tx_done = 0; bus.rx_done = 0;
    bus.tx_clk_en = 0; bus.rx_clk_en = 0;
  endtask

  task automatic check_idle(input string name);
    logic [11:0] o;
    o = observed();
    checks++;
    if (o !== pack(0, 0, 4'hF, 0, 0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, o, pack(0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic run_txn(input int cs, input bit quad, input logic [31:0] cmdw, input int cl,
                         input logic [31:0] aw, input int al, input int dl, input int wl,
                         input int rl, input int mode);
    int ph_q[$];
    int len_q[$];
    int pi, cyc, rises, en_cnt, run_target, ph, len;
    bit entry, finished, is_tx;
    logic [3:0]  e_csn;
    logic [11:0] e_vec, o;
    if (cl != 0) begin ph_q.push_back(P_CMD);   len_q.push_back(cl); end
    if (al != 0) begin ph_q.push_back(P_ADDR);  len_q.push_back(al); end
    if (dl != 0) begin ph_q.push_back(P_DUMMY); len_q.push_back(dl); end
    if (wl != 0) begin ph_q.push_back(P_WR);    len_q.push_back(wl); end
    if (rl != 0) begin ph_q.push_back(P_RD);    len_q.push_back(rl); end
    bus.cs_sel = 2'(cs); bus.en_quad = quad; bus.cmd = cmdw; bus.cmd_len = 6'(cl);
    bus.addr = aw; bus.addr_len = 6'(al); bus.dummy_len = 16'(dl);
    bus.wr_len = 16'(wl); bus.rd_len = 16'(rl);
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    pi = 0; cyc = 0; rises = 0; en_cnt = 0; run_target = 1; entry = 1; finished = 0;
    e_csn = ~(4'b0001 << cs);
    while (!finished) begin
      cyc++;
      if (cyc > 600) begin
        checks++; failures++;
        $display("FAIL timeout: got=%0d cycles required<=600", cyc);
        break;
      end
      o = observed();
      if (pi < ph_q.size()) begin
        ph = ph_q[pi]; len = len_q[pi];
        is_tx = (ph == P_CMD) || (ph == P_ADDR) || (ph == P_WR);
        e_vec = pack(1, 0, e_csn, is_tx && !entry, (ph == P_RD) && !entry,
                     is_tx && entry, (ph == P_RD) && entry,
                     quad && (ph == P_ADDR || ph == P_WR || ph == P_RD),
                     is_tx ? bus.tx_clk_en : (ph == P_RD) ? bus.rx_clk_en : (ph == P_DUMMY));
        checks++;
        if (o !== e_vec) begin
          failures++;
          $display("FAIL phase%0d_ctrl: got=%h expected=%h", ph, o, e_vec);
        end
        if (entry && is_tx) begin
          checks++;
          if (bus.tx_counter !== 16'(len)) begin
            failures++;
            $display("FAIL tx_counter: got=%0d expected=%0d", bus.tx_counter, len);
          end
        end
        if (entry && ph == P_RD) begin
          checks++;
          if (bus.rx_counter !== 16'(len)) begin
            failures++;
            $display("FAIL rx_counter: got=%0d expected=%0d", bus.rx_counter, len);
          end
        end
        if (is_tx) begin
          checks++;
          if (bus.tx_src !== ((ph == P_CMD) ? 2'd1 : (ph == P_ADDR) ? 2'd2 : 2'd0) ||
              (ph == P_CMD && bus.tx_data !== cmdw) || (ph == P_ADDR && bus.tx_data !== aw)) begin
            failures++;
            $display("FAIL tx_source ph%0d: got src=%0d data=%h expected cmd=%h addr=%h",
                     ph, bus.tx_src, bus.tx_data, cmdw, aw);
          end
        end
        if (mode == M_RESET_DUMMY && ph == P_DUMMY) begin
          #1 rstn = 0;
          #1;
          o = observed();
          checks++;
          if (o !== pack(0, 0, 4'hF, 0, 0, 0, 0, 0, 0) || bus.tx_src !== 2'd0 ||
              bus.tx_counter !== 16'd0 || bus.rx_counter !== 16'd0 || bus.tx_data !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: got=%h src=%0d txc=%0d rxc=%0d data=%h expected=%h zeros",
                     o, bus.tx_src, bus.tx_counter, bus.rx_counter, bus.tx_data,
                     pack(0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
          end
          drive_idle();
          @(posedge clk); #1 rstn = 1;
          @(posedge clk); #1;
          check_idle("post_reset_idle");
          return;
        end
        bus.start = 0; bus.tx_done = 0; bus.rx_done = 0;
        bus.tx_clk_en = 1'($urandom); bus.rx_clk_en = 1'($urandom);
        bus.spi_rise = 1'($urandom);
        if (mode == M_DISTURB && cyc == 2) begin
          bus.start = 1; bus.cs_sel = 2'(cs + 1); bus.en_quad = ~quad;
          bus.cmd = $urandom; bus.addr = $urandom;
          bus.cmd_len = 6'($urandom_range(1, 32)); bus.addr_len = 6'($urandom_range(1, 32));
          bus.dummy_len = 16'($urandom_range(1, 8)); bus.wr_len = 16'($urandom_range(1, 99));
          bus.rd_len = 16'($urandom_range(1, 99));
        end
        if (ph == P_DUMMY) begin
          bus.tx_done = 1'($urandom); bus.rx_done = 1'($urandom);
          if (bus.spi_rise) begin
            rises++;
            if (rises == len) begin pi++; entry = 1; rises = 0; end
          end
        end else if (entry) begin
          entry = 0; en_cnt = 0; run_target = $urandom_range(1, 4);
          if (is_tx) bus.tx_done = 1'($urandom); else bus.rx_done = 1'($urandom);
        end else begin
          en_cnt++;
          if (mode == M_ABORT_WR && ph == P_WR) begin
            bus.abort = 1; bus.tx_done = 1; bus.start = 1;
            @(posedge clk); #1;
            check_idle("abort_next_cycle");
            drive_idle();
            @(posedge clk); #1;
            check_idle("abort_stays_idle");
            return;
          end
          if (en_cnt == run_target) begin
            if (is_tx) bus.tx_done = 1; else bus.rx_done = 1;
            pi++; entry = 1;
          end else begin
            if (is_tx) bus.rx_done = 1'($urandom); else bus.tx_done = 1'($urandom);
          end
        end
      end else begin
        e_vec = pack(1, 1, (ph_q.size() == 0) ? e_csn : 4'hF, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o !== e_vec) begin
          failures++;
          $display("FAIL eot_cycle: got=%h expected=%h", o, e_vec);
        end
        drive_idle();
        bus.tx_clk_en = 1;
        finished = 1;
      end
      @(posedge clk); #1;
    end
    drive_idle();
    check_idle("after_eot");
  endtask

  task automatic test_reset();
    drive_idle();
    bus.cs_sel = 0; bus.en_quad = 0; bus.cmd = 0; bus.cmd_len = 0; bus.addr = 0;
    bus.addr_len = 0; bus.dummy_len = 0; bus.wr_len = 0; bus.rd_len = 0;
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_outputs");
    checks++;
    if (bus.tx_src !== 2'd0 || bus.tx_counter !== 16'd0 || bus.rx_counter !== 16'd0 ||
        bus.tx_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: got src=%0d txc=%0d rxc=%0d data=%h expected all 0",
               bus.tx_src, bus.tx_counter, bus.rx_counter, bus.tx_data);
    end
    rstn = 1;
    @(posedge clk); #1;
    check_idle("idle_after_release");
  endtask

  task automatic test_cmd_read();
    run_txn(0, 0, 32'h9F000000, 8, 32'h0, 0, 0, 0, 24, M_NORMAL);
  endtask

  task automatic test_quad_read();
    run_txn(1, 1, 32'hEB000000, 8, 32'h12345600, 24, 6, 0, 32, M_NORMAL);
  endtask

  task automatic test_all_zero();
    run_txn(2, 1, 32'h0, 0, 32'h0, 0, 0, 0, 0, M_NORMAL);
  endtask

  task automatic test_abort_wr();
    run_txn(3, 0, 32'h02000000, 8, 32'hABCDEF00, 24, 0, 40, 0, M_ABORT_WR);
    run_txn(3, 0, 32'h02000000, 8, 32'hABCDEF00, 24, 0, 40, 0, M_NORMAL);
  endtask

  task automatic test_start_ignored();
    run_txn(1, 1, 32'h6B000000, 8, 32'h00FF0000, 16, 4, 12, 20, M_DISTURB);
  endtask

  task automatic test_reset_dummy();
    run_txn(0, 1, 32'hBB000000, 8, 32'h11223300, 24, 5, 0, 16, M_RESET_DUMMY);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      run_txn($urandom_range(0, 3), 1'($urandom), $urandom,
              $urandom_range(0, 1) ? $urandom_range(1, 32) : 0, $urandom,
              $urandom_range(0, 1) ? $urandom_range(1, 32) : 0,
              $urandom_range(0, 1) ? $urandom_range(1, 8) : 0,
              $urandom_range(0, 1) ? $urandom_range(1, 200) : 0,
              $urandom_range(0, 1) ? $urandom_range(1, 200) : 0, M_NORMAL);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cmd_read();
    test_quad_read();
    test_all_zero();
    test_abort_wr();
    test_start_ignored();
    test_reset_dummy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
